// File: rtl/case_sel_mux_if.sv
// case_sel_mux_if: groups the request-side and consumer-side signals of the
// registered case selector. The producer/consumer side takes the master
// modport and the selector takes the slave modport.
interface case_sel_mux_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic             unique_mode;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     req;
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [IW-1:0]    out_idx;
  logic             out_hit;
  logic             err_multi;
  logic             err_none;
  logic [CW-1:0]    multi_cnt;
  logic [CW-1:0]    none_cnt;
  logic             clr_cnt;

  modport master (
    output unique_mode, in_valid, req, in_data, out_ready, clr_cnt,
    input  in_ready, out_valid, out_data, out_idx, out_hit,
           err_multi, err_none, multi_cnt, none_cnt
  );

  modport slave (
    input  unique_mode, in_valid, req, in_data, out_ready, clr_cnt,
    output in_ready, out_valid, out_data, out_idx, out_hit,
           err_multi, err_none, multi_cnt, none_cnt
  );
endinterface

// File: rtl/case_sel_mux.sv
// case_sel_mux: N-channel registered selector with priority/unique case
// checking. The lowest matching channel wins in both modes; a miss either
// holds the previous data or loads DEFAULT_VAL. Full-case (no match) and
// parallel-case (multiple matches in unique mode) violations are reported as
// one-cycle pulses aligned with the offending output item and as saturating
// counters.
module case_sel_mux #(
  parameter int             N            = 4,
  parameter int             W            = 8,
  parameter int             CW           = 8,
  parameter bit             HOLD_ON_MISS = 1'b1,
  parameter logic [W-1:0]   DEFAULT_VAL  = '0
) (
  input logic              clk,
  input logic              rst,
  case_sel_mux_if.slave    bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic           accept;
  logic           hit;
  logic           multi;
  logic [IW-1:0]  win_idx;
  logic [W-1:0]   win_data;

  logic           valid_q;
  logic [W-1:0]   data_q;
  logic [IW-1:0]  idx_q;
  logic           hit_q;
  logic           err_multi_q;
  logic           err_none_q;
  logic [CW-1:0]  multi_cnt_q;
  logic [CW-1:0]  none_cnt_q;

  // The output slot can take a new item when empty or when it drains this cycle.
  assign bus.in_ready = !rst && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign hit   = |bus.req;
  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  assign multi = (bus.req & (bus.req - N'(1))) != '0;

  // Lowest-index matching channel: scan downwards so the last hit written is the lowest.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    win_idx  = '0;
    win_data = bus.in_data[W-1:0];
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_idx  = IW'(i);
        win_data = bus.in_data[i*W +: W];
      end
    end
  end

  // Output item register, valid flag and violation pulses.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      valid_q     <= 1'b0;
      data_q      <= DEFAULT_VAL;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      err_multi_q <= 1'b0;
      err_none_q  <= 1'b0;
    end else begin
      err_multi_q <= accept && hit && multi && bus.unique_mode;
      err_none_q  <= accept && !hit;
      if (accept) begin
        valid_q <= 1'b1;
        hit_q   <= hit;
        idx_q   <= hit ? win_idx : '0;
        if (hit) begin
          data_q <= win_data;
        end else if (!HOLD_ON_MISS) begin
          data_q <= DEFAULT_VAL;
        end
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Saturating violation counters; clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      multi_cnt_q <= '0;
      none_cnt_q  <= '0;
    end else begin
      if (accept && hit && multi && bus.unique_mode && (multi_cnt_q != '1)) begin
        multi_cnt_q <= multi_cnt_q + CW'(1);
      end
      if (accept && !hit && (none_cnt_q != '1)) begin
        none_cnt_q <= none_cnt_q + CW'(1);
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_hit   = hit_q;
  assign bus.err_multi = err_multi_q;
  assign bus.err_none  = err_none_q;
  assign bus.multi_cnt = multi_cnt_q;
  assign bus.none_cnt  = none_cnt_q;
endmodule

// File: doc/case_sel_mux.md
# case_sel_mux

Parametrised N-channel registered selector that implements both SystemVerilog `priority case` and `unique case` checking semantics in hardware. It handles no-match with a hold-last-value or constant-default policy and uses no latches. It sits between request-generating logic and a downstream consumer behind a valid/ready handshake. It reports full-case violations (no match) and parallel-case violations (multiple matches) as pulses and as saturating counters.

## Interface
- `N`, 4: number of input channels (≥2)
- `W`, 8: data width per channel
- `CW`, 8: width of each violation counter
- `HOLD_ON_MISS`, 1: 1 = no-match keeps previous `out_data`; 0 = no-match drives `DEFAULT_VAL`
- `DEFAULT_VAL`, 0: W-bit no-match / reset value of `out_data`
- Derived: `IW` = max(1, $clog2(N))

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `unique_mode`  in  1  0 = priority semantics, 1 = unique semantics; sampled with each accepted item
- `in_valid`  in  1  input item valid
- `in_ready`  out  1  input can be accepted
- `req`  in  N  per-channel match vector; bit i = channel i matches
- `in_data`  in  N*W  channel i in bits [i*W +: W]
- `out_valid`  out  1  output item valid
- `out_ready`  in  1  consumer accepts output
- `out_data`  out  W  selected data
- `out_idx`  out  IW  index of the winning channel; 0 on a miss
- `out_hit`  out  1  1 = at least one `req` bit was set
- `err_multi`  out  1  one-cycle pulse: a unique-mode item had popcount(`req`) > 1
- `err_none`  out  1  one-cycle pulse: an item had `req` == 0, in either mode
- `multi_cnt`  out  CW  saturating count of `err_multi` events
- `none_cnt`  out  CW  saturating count of `err_none` events
- `clr_cnt`  in  1  synchronous clear of both counters

## Operation
- Accept occurs when `in_valid && in_ready`.
- `in_ready = !rst && (!out_valid || out_ready)`. This is combinational.
- Winner selection is the same in both modes: the lowest index i with `req[i]`=1.
- On a hit, the output register loads `out_data` = channel i data, `out_idx` = i, `out_hit` = 1.
- On a miss (`req` == 0):
  - `out_hit` = 0 and `out_idx` = 0.
  - If `HOLD_ON_MISS`=1, `out_data` keeps the current register value. After reset that value is `DEFAULT_VAL`.
  - If `HOLD_ON_MISS`=0, `out_data` = `DEFAULT_VAL`.
- Violation rules, evaluated only on accept:
  - Miss → `err_none` in both modes (full-case check).
  - popcount(`req`) > 1 with `unique_mode`=1 → `err_multi` (parallel-case check).
  - Multiple matches in priority mode are legal and raise no error.
- Counters increment by 1 per event and saturate at 2^CW−1.
- `clr_cnt` zeroes both counters. If it coincides with an increment, clear wins and the result is 0.
- `out_valid` behaviour:
  - Set on accept.
  - Cleared when `out_ready && !in_valid`.
  - Stays 1 when a new item is accepted in the same cycle as the old one drains.
- While `out_valid && !out_ready`, all of `out_data`, `out_idx` and `out_hit` are held stable.
- No combinational path exists from `req` or `in_data` to any output.

## Timing
- Latency is 1 cycle: an item accepted at edge k appears with `out_valid`=1 after edge k.
- Throughput is 1 item per cycle while `out_ready`=1.
- `err_multi` and `err_none` assert for exactly one cycle, in the first cycle that accepted item is presented on the output. The counters show the new value in that same cycle.
- Reset values:
  - `out_valid`=0, `out_data`=`DEFAULT_VAL`, `out_idx`=0, `out_hit`=0
  - `err_multi`=0, `err_none`=0, `multi_cnt`=0, `none_cnt`=0
  - `in_ready`=0 while `rst`=1
- Reset mid-operation discards the held output item. No pulse or counter update occurs for an item presented in a reset cycle.
- A change of `unique_mode` takes effect on the next accepted item only.

## Test plan
- Priority multi-hit: N=4, W=8, `unique_mode`=0, `in_data`={8'h44,8'h33,8'h22,8'h11} (ch3..ch0), `req`=4'b0110.
  - Expect `out_data`=8'h22, `out_idx`=1, `out_hit`=1.
  - Expect `err_multi`=0 and `multi_cnt`=0.
- Unique multi-hit: same stimulus with `unique_mode`=1.
  - Expect `out_data`=8'h22 and `out_idx`=1.
  - Expect a 1-cycle `err_multi` pulse and `multi_cnt`=1.
- Miss policy: follow the unique multi-hit item with `req`=4'b0000.
  - With `HOLD_ON_MISS`=1: expect `out_data`=8'h22, `out_hit`=0, `out_idx`=0, an `err_none` pulse and `none_cnt`=1.
  - With `HOLD_ON_MISS`=0 and `DEFAULT_VAL`=8'hA5: expect `out_data`=8'hA5.
- Backpressure: hold `in_valid`=1 and `out_ready`=0 for 3 cycles.
  - Expect exactly one accept, then `in_ready`=0 with the output stable and a single error pulse only.
  - Raise `out_ready`: expect the next item on the output 1 cycle later and back-to-back throughput thereafter.
- Saturation and clear: CW=2, 5 unique multi-hit accepts.
  - Expect `multi_cnt`=3.
  - Assert `clr_cnt` in the same cycle as a 6th multi-hit event: expect `multi_cnt`=0.
- Reset mid-operation: hold `out_valid`=1 with `out_ready`=0 and `none_cnt`=2, then pulse `rst` for 1 cycle.
  - Expect `out_valid`=0, `out_data`=`DEFAULT_VAL`, both counters 0, and `in_ready`=0 during reset.
